// File: rtl/viterbi_traceback_ctrl_if.sv
// Stream interface between the ACS stage, the traceback controller and the
// downstream bit consumer.
//   in_valid/in_ready/in_dec/in_last    : survivor decision vectors, one per trellis step
//   out_valid/out_ready/out_bit/out_last : decoded message bits, forward order
// The slave modport is the controller; the master modport is its environment.
interface viterbi_traceback_ctrl_if #(
   parameter int M = 2
);
   logic              in_valid;
   logic              in_ready;
   logic [2**M-1:0]   in_dec;
   logic              in_last;
   logic              out_valid;
   logic              out_ready;
   logic              out_bit;
   logic              out_last;

   modport master (
      output in_valid, in_dec, in_last, out_ready,
      input  in_ready, out_valid, out_bit, out_last
   );

   modport slave (
      input  in_valid, in_dec, in_last, out_ready,
      output in_ready, out_valid, out_bit, out_last
   );
endinterface

// File: rtl/viterbi_traceback_ctrl.sv
// Frame-based Viterbi traceback controller.
// Stores one survivor decision vector per trellis step, then, after the tail
// step of the frame, traces back from state 0 and emits the decoded message
// bits (tail bits dropped) in forward order on a valid/ready stream.
// Ports:
//   clk   : rising-edge clock
//   reset : asynchronous active-low reset
//   strm  : decision input stream and decoded-bit output stream (slave side)
//   busy  : high while tracing back or emitting
//   err   : sticky frame error (overlong frame without tail, or frame too
//           short to carry a message); cleared by the next frame's first beat
module viterbi_traceback_ctrl #(
   parameter int M       = 2,
   parameter int MAX_LEN = 64
) (
   input  logic                       clk,
   input  logic                       reset,
   viterbi_traceback_ctrl_if.slave    strm,
   output logic                       busy,
   output logic                       err
);
   localparam int NS = 2**M;
   localparam int IW = $clog2(MAX_LEN);
   localparam int LW = $clog2(MAX_LEN + 1);

   typedef enum logic [1:0] {S_IDLE, S_WRITE, S_TRACE, S_EMIT} state_t;

   state_t            state_q, state_d;
   logic [LW-1:0]     len_q, len_d;
   logic [IW-1:0]     idx_q, idx_d;
   logic [IW-1:0]     ecnt_q, ecnt_d;
   logic [M-1:0]      tstate_q, tstate_d;
   logic              in_ready_q, in_ready_d;
   logic              out_valid_q, out_valid_d;
   logic              out_bit_q, out_bit_d;
   logic              out_last_q, out_last_d;
   logic              err_q, err_d;

   // Survivor memory and traced-back bits: pure data, never reset.
   logic [NS-1:0]     mem_q [MAX_LEN];
   logic [MAX_LEN-1:0] bits_q;

   logic              accept;
   logic              dec_bit;
   logic [LW-1:0]     last_msg;

   assign accept   = strm.in_valid & in_ready_q;
   assign dec_bit  = mem_q[idx_q][tstate_q];
   // Index of the final message bit (tail bits are never emitted).
   assign last_msg = len_q - LW'(M + 1);

   always_ff @(posedge clk) begin
      if (accept)
         mem_q[len_q[IW-1:0]] <= strm.in_dec;
      if (state_q == S_TRACE)
         bits_q[idx_q] <= tstate_q[M-1];
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q     <= S_IDLE;
         len_q       <= '0;
         idx_q       <= '0;
         ecnt_q      <= '0;
         tstate_q    <= '0;
         in_ready_q  <= 1'b0;
         out_valid_q <= 1'b0;
         out_bit_q   <= 1'b0;
         out_last_q  <= 1'b0;
         err_q       <= 1'b0;
      end else begin
         state_q     <= state_d;
         len_q       <= len_d;
         idx_q       <= idx_d;
         ecnt_q      <= ecnt_d;
         tstate_q    <= tstate_d;
         in_ready_q  <= in_ready_d;
         out_valid_q <= out_valid_d;
         out_bit_q   <= out_bit_d;
         out_last_q  <= out_last_d;
         err_q       <= err_d;
      end
   end

   always_comb begin
      state_d     = state_q;
      len_d       = len_q;
      idx_d       = idx_q;
      ecnt_d      = ecnt_q;
      tstate_d    = tstate_q;
      in_ready_d  = in_ready_q;
      out_valid_d = out_valid_q;
      out_bit_d   = out_bit_q;
      out_last_d  = out_last_q;
      err_d       = err_q;
      case (state_q)
         S_IDLE, S_WRITE: begin
            // in_ready comes up on the first clock after reset release.
            in_ready_d = 1'b1;
            if (accept) begin
               len_d = len_q + LW'(1);
               if (state_q == S_IDLE) begin
                  err_d   = 1'b0;
                  state_d = S_WRITE;
               end
               if (strm.in_last || (len_q == LW'(MAX_LEN - 1))) begin
                  state_d    = S_TRACE;
                  in_ready_d = 1'b0;
                  idx_d      = len_q[IW-1:0];
                  tstate_d   = '0;
                  if (!strm.in_last)
                     err_d = 1'b1;
               end
            end
         end
         S_TRACE: begin
            // Bit for this step is the state MSB; the decision selects the
            // predecessor state.
            tstate_d = {tstate_q[M-2:0], dec_bit};
            idx_d    = idx_q - IW'(1);
            if (idx_q == '0) begin
               if (len_q <= LW'(M)) begin
                  state_d    = S_IDLE;
                  err_d      = 1'b1;
                  len_d      = '0;
                  in_ready_d = 1'b1;
               end else begin
                  // bit[0] is being written this cycle, so present it directly.
                  state_d     = S_EMIT;
                  out_valid_d = 1'b1;
                  out_bit_d   = tstate_q[M-1];
                  out_last_d  = (len_q == LW'(M + 1));
                  ecnt_d      = '0;
               end
            end
         end
         S_EMIT: begin
            if (out_valid_q && strm.out_ready) begin
               if (out_last_q) begin
                  state_d     = S_IDLE;
                  out_valid_d = 1'b0;
                  out_last_d  = 1'b0;
                  len_d       = '0;
                  in_ready_d  = 1'b1;
               end else begin
                  ecnt_d     = ecnt_q + IW'(1);
                  out_bit_d  = bits_q[ecnt_q + IW'(1)];
                  out_last_d = ((LW'(ecnt_q) + LW'(1)) == last_msg);
               end
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   assign strm.in_ready  = in_ready_q;
   assign strm.out_valid = out_valid_q;
   assign strm.out_bit   = out_bit_q;
   assign strm.out_last  = out_last_q;
   assign busy           = (state_q == S_TRACE) || (state_q == S_EMIT);
   assign err            = err_q;
endmodule

// File: tb/tb_viterbi_traceback_ctrl.sv
module tb_viterbi_traceback_ctrl;
   localparam int M    = 2;
   localparam int NS   = 1 << M;
   localparam int MAXL = 64;
   localparam int TMO  = 400;

   logic clk = 1'b0;
   logic reset;
   logic busy, err;

   always #5 clk = ~clk;

   viterbi_traceback_ctrl_if #(.M(M)) bus ();

   viterbi_traceback_ctrl #(.M(M), .MAX_LEN(MAXL)) dut (
      .clk   (clk),
      .reset (reset),
      .strm  (bus),
      .busy  (busy),
      .err   (err)
   );

   int n_tests = 0;
   int n_fail  = 0;

   logic [NS-1:0] fr_dec [MAXL];
   bit  exp_q [$];
   bit  got_q [$];
   int  last_pos, n_viol, latency, mism;
   bit  tmo;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Reference: follow the survivor path backwards from state 0; the message
   // bit of step t is the MSB of the state reached after step t.
   function automatic void build_expected(input int len);
      int s;
      bit b [MAXL];
      s = 0;
      exp_q.delete();
      for (int i = len - 1; i >= 0; i--) begin
         b[i] = s[M-1];
         s = ((s << 1) | int'(fr_dec[i][s])) & (NS - 1);
      end
      for (int i = 0; i < len - M; i++) exp_q.push_back(b[i]);
   endfunction

   function automatic void load_known();
      fr_dec[0] = 4'b0000; fr_dec[1] = 4'b0000; fr_dec[2] = 4'b0100;
      fr_dec[3] = 4'b0000; fr_dec[4] = 4'b0010; fr_dec[5] = 4'b0001;
   endfunction

   function automatic void compare_queues();
      mism = 0;
      if (got_q.size() != exp_q.size()) mism = 1;
      else for (int i = 0; i < got_q.size(); i++) if (got_q[i] != exp_q[i]) mism++;
   endfunction

   // Drives beats first..len-1; returns #1 after the edge accepting the last one.
   task automatic send_frame(input int first, input int len, input bit with_last, input bit gaps);
      int w;
      for (int i = first; i < len; i++) begin
         if (gaps) begin
            while ($urandom_range(3) == 0) begin
               bus.in_valid = 1'b0;
               bus.in_dec   = NS'($urandom);
               bus.in_last  = 1'($urandom_range(1));
               step();
            end
         end
         bus.in_valid = 1'b1;
         bus.in_dec   = fr_dec[i];
         bus.in_last  = with_last && (i == len - 1);
         w = 0;
         while (!bus.in_ready && w < TMO) begin step(); w++; end
         if (w >= TMO) begin tmo = 1'b1; break; end
         step();
      end
      bus.in_valid = 1'b0;
      bus.in_last  = 1'b0;
      bus.in_dec   = '0;
   endtask

   // Collects decoded bits until out_last is handshaken. mode 0: ready always,
   // 1: ready pattern 1,0,0,1,0,1..., 2: random ready.
   task automatic collect(input int mode);
      bit pat [6] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
      bit prev_stall, prev_bit, prev_last, seen, r, done;
      int cyc;
      got_q.delete();
      last_pos = -1; n_viol = 0; latency = -1;
      prev_stall = 0; prev_bit = 0; prev_last = 0; seen = 0; done = 0;
      cyc = 0;
      while (!done && cyc < TMO) begin
         step();
         cyc++;
         if (bus.out_valid && !seen) begin seen = 1; latency = cyc; end
         if (prev_stall && (!bus.out_valid || bus.out_bit !== prev_bit || bus.out_last !== prev_last))
            n_viol++;
         case (mode)
            0:       r = 1'b1;
            1:       r = pat[(latency < 0 ? 0 : cyc - latency) % 6];
            default: r = 1'($urandom_range(1));
         endcase
         bus.out_ready = r;
         if (bus.out_valid && r) begin
            got_q.push_back(bus.out_bit);
            if (bus.out_last) begin last_pos = got_q.size() - 1; done = 1; end
         end
         prev_stall = bus.out_valid && !r;
         prev_bit   = bus.out_bit;
         prev_last  = bus.out_last;
      end
      if (!done) tmo = 1'b1;
   endtask

   task automatic test_reset();
      reset = 1'b0;
      bus.in_valid = 1'b0; bus.in_dec = '0; bus.in_last = 1'b0; bus.out_ready = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      n_tests++; if (bus.in_ready !== 1'b0) begin n_fail++; $display("FAIL reset_in_ready: got %b want 0", bus.in_ready); end
      n_tests++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid: got %b want 0", bus.out_valid); end
      n_tests++; if ({bus.out_bit, bus.out_last} !== 2'b00) begin n_fail++; $display("FAIL reset_out_bit_last: got %b want 00", {bus.out_bit, bus.out_last}); end
      n_tests++; if ({busy, err} !== 2'b00) begin n_fail++; $display("FAIL reset_busy_err: got %b want 00", {busy, err}); end
      @(negedge clk);
      reset = 1'b1;
      step();
      n_tests++; if (bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL release_in_ready: got %b want 1", bus.in_ready); end
   endtask

   task automatic test_known_frame(input int mode);
      tmo = 1'b0;
      load_known();
      send_frame(0, 6, 1'b1, 1'b0);
      n_tests++; if ({busy, bus.in_ready} !== 2'b10) begin n_fail++; $display("FAIL known%0d_trace_state: busy,in_ready got %b want 10", mode, {busy, bus.in_ready}); end
      collect(mode);
      exp_q = '{1'b1, 1'b0, 1'b1, 1'b1};
      compare_queues();
      n_tests++; if (tmo) begin n_fail++; $display("FAIL known%0d_timeout: got timeout want completion", mode); end
      n_tests++; if (latency != 6) begin n_fail++; $display("FAIL known%0d_latency: got %0d want 6", mode, latency); end
      n_tests++; if (mism != 0) begin n_fail++; $display("FAIL known%0d_bits: got %0d bits (%0d mismatches) want 1,0,1,1", mode, got_q.size(), mism); end
      n_tests++; if (last_pos != 3) begin n_fail++; $display("FAIL known%0d_out_last: got position %0d want 3", mode, last_pos); end
      n_tests++; if (n_viol != 0) begin n_fail++; $display("FAIL known%0d_stall_stable: got %0d changes want 0", mode, n_viol); end
      n_tests++; if (err !== 1'b0) begin n_fail++; $display("FAIL known%0d_err: got %b want 0", mode, err); end
      step();
      n_tests++; if ({bus.out_valid, busy, bus.in_ready} !== 3'b001) begin n_fail++; $display("FAIL known%0d_return_idle: valid,busy,ready got %b want 001", mode, {bus.out_valid, busy, bus.in_ready}); end
   endtask

   task automatic test_max_tail();
      tmo = 1'b0;
      for (int i = 0; i < MAXL; i++) fr_dec[i] = '0;
      send_frame(0, MAXL, 1'b1, 1'b0);
      build_expected(MAXL);
      collect(0);
      compare_queues();
      n_tests++; if (tmo) begin n_fail++; $display("FAIL max_tail_timeout: got timeout want completion"); end
      n_tests++; if (got_q.size() != 62 || mism != 0) begin n_fail++; $display("FAIL max_tail_bits: got %0d bits (%0d mismatches) want 62 zeros", got_q.size(), mism); end
      n_tests++; if (last_pos != 61) begin n_fail++; $display("FAIL max_tail_out_last: got position %0d want 61", last_pos); end
      n_tests++; if (latency != MAXL) begin n_fail++; $display("FAIL max_tail_latency: got %0d want %0d", latency, MAXL); end
      n_tests++; if (err !== 1'b0) begin n_fail++; $display("FAIL max_tail_err: got %b want 0", err); end
      step();
   endtask

   task automatic test_max_no_last();
      logic [NS-1:0] held;
      tmo = 1'b0;
      for (int i = 0; i < MAXL; i++) fr_dec[i] = NS'($urandom);
      send_frame(0, MAXL, 1'b0, 1'b1);
      n_tests++; if ({err, busy, bus.in_ready} !== 3'b110) begin n_fail++; $display("FAIL nolast_forced_trace: err,busy,ready got %b want 110", {err, busy, bus.in_ready}); end
      build_expected(MAXL);
      held = NS'($urandom);
      bus.in_valid = 1'b1; bus.in_dec = held; bus.in_last = 1'b0;
      collect(2);
      compare_queues();
      n_tests++; if (tmo) begin n_fail++; $display("FAIL nolast_timeout: got timeout want completion"); end
      n_tests++; if (mism != 0) begin n_fail++; $display("FAIL nolast_bits: got %0d bits (%0d mismatches) want %0d", got_q.size(), mism, exp_q.size()); end
      n_tests++; if (last_pos != 61) begin n_fail++; $display("FAIL nolast_out_last: got position %0d want 61", last_pos); end
      n_tests++; if (latency != MAXL) begin n_fail++; $display("FAIL nolast_latency: got %0d want %0d", latency, MAXL); end
      n_tests++; if ({bus.in_ready, err} !== 2'b01) begin n_fail++; $display("FAIL nolast_hold_beat: ready,err got %b want 01", {bus.in_ready, err}); end
      step();
      n_tests++; if ({bus.in_ready, err, busy} !== 3'b110) begin n_fail++; $display("FAIL nolast_idle: ready,err,busy got %b want 110", {bus.in_ready, err, busy}); end
      step();
      n_tests++; if (err !== 1'b0) begin n_fail++; $display("FAIL nolast_err_clear: got %b want 0", err); end
      fr_dec[0] = held;
      for (int i = 1; i < 8; i++) fr_dec[i] = NS'($urandom);
      send_frame(1, 8, 1'b1, 1'b0);
      build_expected(8);
      collect(0);
      compare_queues();
      n_tests++; if (tmo || mism != 0) begin n_fail++; $display("FAIL nolast_next_frame: got %0d bits (%0d mismatches, timeout %b) want %0d", got_q.size(), mism, tmo, exp_q.size()); end
      step();
   endtask

   task automatic test_short();
      bit saw_valid;
      tmo = 1'b0;
      fr_dec[0] = NS'($urandom); fr_dec[1] = NS'($urandom);
      send_frame(0, 2, 1'b1, 1'b0);
      saw_valid = bus.out_valid;
      n_tests++; if (busy !== 1'b1) begin n_fail++; $display("FAIL short_busy0: got %b want 1", busy); end
      step();
      saw_valid |= bus.out_valid;
      n_tests++; if (busy !== 1'b1) begin n_fail++; $display("FAIL short_busy1: got %b want 1", busy); end
      step();
      n_tests++; if ({busy, bus.in_ready, err} !== 3'b011) begin n_fail++; $display("FAIL short_idle: busy,ready,err got %b want 011", {busy, bus.in_ready, err}); end
      for (int i = 0; i < 6; i++) begin saw_valid |= bus.out_valid; step(); end
      n_tests++; if (saw_valid !== 1'b0) begin n_fail++; $display("FAIL short_no_output: got out_valid %b want 0", saw_valid); end
   endtask

   task automatic test_reset_mid();
      tmo = 1'b0;
      for (int i = 0; i < 6; i++) fr_dec[i] = NS'($urandom);
      send_frame(0, 3, 1'b0, 1'b0);
      #2 reset = 1'b0;
      #1;
      n_tests++; if ({bus.in_ready, busy, bus.out_valid} !== 3'b000) begin n_fail++; $display("FAIL midreset_outputs: ready,busy,valid got %b want 000", {bus.in_ready, busy, bus.out_valid}); end
      repeat (2) @(posedge clk);
      @(negedge clk);
      reset = 1'b1;
      step();
      load_known();
      send_frame(0, 6, 1'b1, 1'b0);
      collect(0);
      exp_q = '{1'b1, 1'b0, 1'b1, 1'b1};
      compare_queues();
      n_tests++; if (tmo || mism != 0) begin n_fail++; $display("FAIL midreset_new_frame: got %0d bits (%0d mismatches) want 1,0,1,1", got_q.size(), mism); end
      n_tests++; if (latency != 6) begin n_fail++; $display("FAIL midreset_latency: got %0d want 6", latency); end
      step();
   endtask

   task automatic test_random_frames();
      int len;
      for (int f = 0; f < 8; f++) begin
         tmo = 1'b0;
         len = $urandom_range(MAXL, M + 1);
         for (int i = 0; i < MAXL; i++) fr_dec[i] = NS'($urandom);
         send_frame(0, len, 1'b1, 1'b1);
         build_expected(len);
         collect(2);
         compare_queues();
         n_tests++; if (tmo || mism != 0) begin n_fail++; $display("FAIL rand%0d_bits: len %0d got %0d bits (%0d mismatches) want %0d", f, len, got_q.size(), mism, exp_q.size()); end
         n_tests++; if (last_pos != len - M - 1 || latency != len) begin n_fail++; $display("FAIL rand%0d_timing: last %0d latency %0d want %0d %0d", f, last_pos, latency, len - M - 1, len); end
         n_tests++; if (n_viol != 0 || err !== 1'b0) begin n_fail++; $display("FAIL rand%0d_stall_err: changes %0d err %b want 0 0", f, n_viol, err); end
         step();
      end
   endtask

   initial begin
      #3000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      test_reset();
      test_known_frame(0);
      test_known_frame(1);
      test_max_tail();
      test_max_no_last();
      test_short();
      test_reset_mid();
      test_random_frames();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
